// File: rtl/lsu_mem_initiator_if.sv
// Pipeline request/response and data-memory port bundle for the MEM-stage LSU.
// master: pipeline + memory side, slave: lsu_mem_initiator.
interface lsu_mem_initiator_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_store;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  busy;
    logic [ADDR_WIDTH-1:0] mem_read_addr;
    logic [ADDR_WIDTH-1:0] mem_write_addr;
    logic [31:0]           mem_write_data;
    logic                  mem_we;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
    logic [31:0]           mem_read_data;

    modport master (
        output req_valid, req_is_store, req_addr, req_wdata,
        output req_size, req_unsigned, mem_read_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  mem_read_addr, mem_write_addr, mem_write_data,
        input  mem_we, mem_size, mem_unsigned
    );

    modport slave (
        input  req_valid, req_is_store, req_addr, req_wdata,
        input  req_size, req_unsigned, mem_read_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output mem_read_addr, mem_write_addr, mem_write_data,
        output mem_we, mem_size, mem_unsigned
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// MEM-stage load/store initiator; misaligned half/word split into byte ops.
// Define LSU_MISALIGN_TRAP_EN to report misaligned accesses as errors instead.
module lsu_mem_initiator #(
    parameter int ADDR_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    lsu_mem_initiator_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ERR
    } state_t;

    state_t state;
    state_t state_nxt;

    logic        ready;
    logic        accept;
    logic        misalign;
    logic        bad;
    logic        last;
    logic [1:0]  k_inc;
    logic [15:0] half_w;
    logic [31:0] ld_data;

    logic        split_q;
    logic        store_q;
    logic        uns_q;
    logic [1:0]  k_q;
    logic [1:0]  kmax_q;
    logic [31:0] wdata_q;
    logic [23:0] asm_q;

    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic                  mem_we_q;
    logic [1:0]            mem_size_q;
    logic                  mem_uns_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_rdata_q;

    assign accept = bus.req_valid && ready;
    assign misalign = (bus.req_size == 2'b01 && bus.req_addr[0])
                   || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    assign bad = (bus.req_size == 2'b11) || misalign;
`else
    assign bad = (bus.req_size == 2'b11);
`endif
    assign last = (k_q == kmax_q);
    assign k_inc = k_q + 2'd1;
    assign half_w = {bus.mem_read_data[7:0], asm_q[7:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (accept) state_nxt = bad ? S_ERR : S_ACCESS;
            S_ACCESS: if (last) state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ready    = (state == S_IDLE);
        bus.req_ready = ready;
        bus.busy      = ~ready;
    end

    // Final byte of a split load arrives this cycle; merge with assembled bytes.
    always_comb begin
        ld_data = bus.mem_read_data;
        if (split_q) begin
            if (kmax_q == 2'd1)
                ld_data = {{16{half_w[15] & ~uns_q}}, half_w};
            else
                ld_data = {bus.mem_read_data[7:0], asm_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            split_q     <= 1'b0;
            store_q     <= 1'b0;
            uns_q       <= 1'b0;
            k_q         <= 2'd0;
            kmax_q      <= 2'd0;
            wdata_q     <= 32'd0;
            asm_q       <= 24'd0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 2'd0;
            mem_uns_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state == S_IDLE && accept) begin
                split_q <= misalign;
                store_q <= bus.req_is_store;
                uns_q   <= bus.req_unsigned;
                wdata_q <= bus.req_wdata;
                k_q     <= 2'd0;
                if (bad) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    rsp_rdata_q <= 32'd0;
                end else begin
                    mem_addr_q <= bus.req_addr;
                    mem_we_q   <= bus.req_is_store;
                    if (misalign) begin
                        kmax_q      <= (bus.req_size == 2'b01) ? 2'd1 : 2'd3;
                        mem_size_q  <= 2'b00;
                        mem_uns_q   <= 1'b1;
                        mem_wdata_q <= {24'd0, bus.req_wdata[7:0]};
                    end else begin
                        kmax_q      <= 2'd0;
                        mem_size_q  <= bus.req_size;
                        mem_uns_q   <= bus.req_unsigned;
                        mem_wdata_q <= bus.req_wdata;
                    end
                end
            end
            if (state == S_ACCESS) begin
                if (last) begin
                    mem_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= store_q ? 32'd0 : ld_data;
                end else begin
                    k_q         <= k_inc;
                    mem_addr_q  <= mem_addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    mem_wdata_q <= {24'd0, wdata_q[{k_inc, 3'b000} +: 8]};
                    case (k_q)
                        2'd0:    asm_q[7:0]   <= bus.mem_read_data[7:0];
                        2'd1:    asm_q[15:8]  <= bus.mem_read_data[7:0];
                        2'd2:    asm_q[23:16] <= bus.mem_read_data[7:0];
                        default: asm_q        <= asm_q;
                    endcase
                end
            end
        end
    end

    assign bus.mem_read_addr  = mem_addr_q;
    assign bus.mem_write_addr = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_size       = mem_size_q;
    assign bus.mem_unsigned   = mem_uns_q;
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_err        = rsp_err_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
endmodule
